uart_receiver: RTL and testbench

MMIO UART receiver; the receive-side counterpart of the existing UART transmit peripheral. It deserialises 8N1 frames from the board's `uart_rx` pin into a small receive FIFO. The core reads the FIFO through a data register and receive state through a status register on the shared data-memory bus. It sits beside the LED and UART-TX peripherals, and its `mmio_done` feeds the Memory done mux.

---
 rtl/uart_receiver.sv | 204 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receiver: deserialises frames from rx into a small FIFO read over MMIO, with sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking (default build is 8N1).
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [15:0] ADDR_DATA    = 16'hFF02,
    parameter logic [15:0] ADDR_STATUS  = 16'hFF03
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic [15:0] mmio_addr,
    input  logic        mmio_req,
    input  logic        mmio_write,
    input  logic [7:0]  mmio_data_in,
    output logic [7:0]  mmio_data_out,
    output logic        mmio_done,
    output logic        rx_valid
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]      DEPTH    = (AW + 1)'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d, rxs_q, rxs_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             frame_perr;
    logic             stop_ok, stop_bad;

    logic             perr_flag_q, perr_flag_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [AW:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, count_q, count_d;
    logic             served_q, served_d, done_q, done_d;
    logic [7:0]       data_out_q, data_out_d;

    logic             hit_data, hit_status, accept, fifo_empty, fifo_full, push, pop;
    logic [2:0]       clr;
    logic             unused_bits;

`ifdef UART_RX_PARITY_EN
    logic perr_q, perr_d;
    assign frame_perr = perr_q;
`else
    assign frame_perr = 1'b0;
`endif

    assign sync1_d = rx;
    assign rxs_d   = sync1_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 1'b1;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
`ifdef UART_RX_PARITY_EN
        perr_d    = perr_q;
`endif
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (bit_cnt_q == HALF_BIT) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_cnt_q == FULL_BIT) begin
                    bit_cnt_d      = '0;
                    shreg_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_cnt_q == FULL_BIT) begin
                    bit_cnt_d = '0;
                    perr_d    = rxs_q ^ (^shreg_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop so a start bit right after the stop bit is caught.
                if (bit_cnt_q == FULL_BIT) begin
                    bit_cnt_d = '0;
                    stop_ok   = rxs_q;
                    stop_bad  = !rxs_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        hit_data   = (mmio_addr == ADDR_DATA);
        hit_status = (mmio_addr == ADDR_STATUS);
        accept     = mmio_req && (hit_data || hit_status) && !served_q;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH);
        pop        = accept && !mmio_write && hit_data && !fifo_empty;
        push       = stop_ok && !frame_perr && (!fifo_full || pop);
        clr        = (accept && mmio_write && hit_status) ? mmio_data_in[4:2] : 3'b000;

        // Set terms are ORed after the clear so a same-cycle set survives.
        perr_flag_d = (perr_flag_q & ~clr[2]) | (stop_ok && frame_perr);
        ferr_d      = (ferr_q & ~clr[1]) | stop_bad;
        ovr_d       = (ovr_q & ~clr[0]) | (stop_ok && !frame_perr && fifo_full && !pop);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[AW-1:0]] = shreg_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        served_d   = mmio_req ? (served_q | accept) : 1'b0;
        done_d     = accept;
        data_out_d = data_out_q;
        if (accept && !mmio_write) begin
            if (hit_data)
                data_out_d = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
            else
                data_out_d = {3'b000, perr_flag_q, ferr_q, ovr_q, fifo_full, !fifo_empty};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            bit_cnt_q   <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
`ifdef UART_RX_PARITY_EN
            perr_q      <= 1'b0;
`endif
            perr_flag_q <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            mem_q       <= '{default: '0};
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            served_q    <= 1'b0;
            done_q      <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            bit_cnt_q   <= bit_cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
`ifdef UART_RX_PARITY_EN
            perr_q      <= perr_d;
`endif
            perr_flag_q <= perr_flag_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            served_q    <= served_d;
            done_q      <= done_d;
            data_out_q  <= data_out_d;
        end
    end

    assign mmio_data_out = data_out_q;
    assign mmio_done     = done_q;
    assign rx_valid      = !fifo_empty;

    assign unused_bits = ^{mmio_data_in[7:5], mmio_data_in[1:0], rd_ptr_q[AW], wr_ptr_q[AW]};
endmodule

// File: tb/tb_uart_receiver.sv
// Randomised self-checking bench for uart_receiver against a transaction-level queue model.
`timescale 1ns/1ps
module tb_uart_receiver;
    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] A_DATA = 16'hFF02;
    localparam logic [15:0] A_STAT = 16'hFF03;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        rx;
    logic [15:0] mmio_addr;
    logic        mmio_req;
    logic        mmio_write;
    logic [7:0]  mmio_data_in;
    logic [7:0]  mmio_data_out;
    logic        mmio_done;
    logic        rx_valid;

    always #5 clock = ~clock;

    uart_receiver #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_DATA   (A_DATA),
        .ADDR_STATUS (A_STAT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rx           (rx),
        .mmio_addr    (mmio_addr),
        .mmio_req     (mmio_req),
        .mmio_write   (mmio_write),
        .mmio_data_in (mmio_data_in),
        .mmio_data_out(mmio_data_out),
        .mmio_done    (mmio_done),
        .rx_valid     (rx_valid)
    );

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned model_q[$];
    bit m_perr, m_ferr, m_ovr;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_status();
        return {3'b000, m_perr, m_ferr, m_ovr, model_q.size() == DEPTH, model_q.size() != 0};
    endfunction

    function automatic bit even_par(input logic [7:0] d);
        return ^d;
    endfunction

    task automatic model_frame(input logic [7:0] d, input bit stop_bit, input bit par_bit);
        if (!stop_bit)                          m_ferr = 1'b1;
        else if (PARITY && par_bit != ^d)       m_perr = 1'b1;
        else if (model_q.size() == DEPTH)       m_ovr  = 1'b1;
        else                                    model_q.push_back(d);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clock);
    endtask

    // Entered and left on a negedge; bits change on negedges so sampling is race-free.
    task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PARITY) drive_bit(par_bit);
        drive_bit(stop_bit);
        rx = 1'b1;
        model_frame(d, stop_bit, par_bit);
        if (!stop_bit) repeat (2 * CPB) @(negedge clock);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (mmio_done) break;
        end
        check_eq({tag, "_done"}, mmio_done, 1'b1);
    endtask

    task automatic mmio_rd(input string tag, input logic [15:0] addr, output logic [7:0] data);
        mmio_addr  = addr;
        mmio_write = 1'b0;
        mmio_req   = 1'b1;
        wait_done(tag);
        data     = mmio_data_out;
        mmio_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic mmio_wr(input string tag, input logic [15:0] addr, input logic [7:0] data);
        mmio_addr    = addr;
        mmio_write   = 1'b1;
        mmio_data_in = data;
        mmio_req     = 1'b1;
        wait_done(tag);
        mmio_req   = 1'b0;
        mmio_write = 1'b0;
        @(negedge clock);
    endtask

    task automatic chk_status(input string tag);
        logic [7:0] v;
        mmio_rd(tag, A_STAT, v);
        check_eq(tag, v, model_status());
    endtask

    task automatic chk_data(input string tag);
        logic [7:0] v, e;
        if (model_q.size() != 0) e = model_q.pop_front();
        else                     e = 8'h00;
        mmio_rd(tag, A_DATA, v);
        check_eq(tag, v, e);
    endtask

    task automatic clear_flags(input string tag, input logic [7:0] mask);
        mmio_wr(tag, A_STAT, mask);
        if (mask[4]) m_perr = 1'b0;
        if (mask[3]) m_ferr = 1'b0;
        if (mask[2]) m_ovr  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat;
        int         pulses;
        logic [7:0] d, held_v, v;
        bit         stop_bit, par_bit;

        rx = 1'b1; reset = 1'b1; mmio_req = 1'b0; mmio_addr = '0;
        mmio_write = 1'b0; mmio_data_in = '0;
        repeat (3) @(negedge clock);
        check_eq("rst_data_out", mmio_data_out, 8'h00);
        check_eq("rst_done", mmio_done, 1'b0);
        check_eq("rst_rx_valid", rx_valid, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk_status("rst_status");

        // Single byte with push latency measured from the falling edge
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, even_par(8'hA5));
            begin
                for (int i = 0; i < 400; i++) begin
                    @(posedge clock);
                    lat++;
                    @(negedge clock);
                    if (rx_valid) break;
                end
            end
        join
        check_eq("latency", lat[15:0], 16'(2 + CPB / 2 + 9 * CPB + 1 + (PARITY ? CPB : 0)));
        chk_status("single_status1");
        chk_data("single_data");
        chk_status("single_status2");

        // Back-to-back frames into a 4-deep FIFO; the fifth overruns
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            send_frame(d, 1'b1, even_par(d));
        end
        check_eq("b2b_rx_valid", rx_valid, 1'b1);
        chk_status("b2b_status");
        for (int i = 0; i < 5; i++) chk_data("b2b_data");
        clear_flags("b2b_clr", 8'h04);
        chk_status("b2b_status_clr");

        // Framing error
        send_frame(8'h3C, 1'b0, even_par(8'h3C));
        chk_status("ferr_status");
        check_eq("ferr_rx_valid", rx_valid, 1'b0);
        clear_flags("ferr_clr", 8'h08);

        // Start glitch
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        check_eq("glitch_rx_valid", rx_valid, 1'b0);
        chk_status("glitch_status");
        send_frame(8'h5A, 1'b1, even_par(8'h5A));
        chk_data("glitch_data");

        // Held request: one done pulse and one pop
        send_frame(8'h3E, 1'b1, even_par(8'h3E));
        send_frame(8'hC1, 1'b1, even_par(8'hC1));
        mmio_addr = A_DATA; mmio_write = 1'b0; mmio_req = 1'b1;
        pulses = 0;
        repeat (5) begin
            @(negedge clock);
            if (mmio_done) pulses++;
        end
        held_v = mmio_data_out;
        mmio_req = 1'b0;
        @(negedge clock);
        check_eq("held_pulses", pulses[15:0], 16'd1);
        check_eq("held_data", held_v, model_q.pop_front());
        chk_status("held_status");

        // Unmapped address: no done, no pop
        mmio_addr = 16'hFF04; mmio_req = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clock);
            if (mmio_done) pulses++;
        end
        mmio_req = 1'b0;
        @(negedge clock);
        check_eq("unmapped_pulses", pulses[15:0], 16'd0);
        mmio_wr("wr_data_nop", A_DATA, 8'hFF);
        chk_data("held_data2");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        chk_status("perr_status");
        check_eq("perr_rx_valid", rx_valid, 1'b0);
        clear_flags("perr_clr", 8'h10);
        chk_status("perr_status_clr");
`endif

        // Reset in the middle of data bit 3
        send_frame(8'h11, 1'b0, even_par(8'h11));
        send_frame(8'h81, 1'b1, even_par(8'h81));
        chk_status("pre_rst_status");
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_eq("midrst_data_out", mmio_data_out, 8'h00);
        check_eq("midrst_done", mmio_done, 1'b0);
        check_eq("midrst_rx_valid", rx_valid, 1'b0);
        reset = 1'b0;
        rx = 1'b1;
        model_q.delete();
        m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (CPB) @(negedge clock);
        chk_status("midrst_status");
        send_frame(8'hC3, 1'b1, even_par(8'hC3));
        chk_data("midrst_data");

        // Randomised frames and bus traffic
        for (int n = 0; n < 24; n++) begin
            d        = 8'($urandom);
            stop_bit = ($urandom_range(0, 7) != 0);
            par_bit  = even_par(d) ^ ($urandom_range(0, 5) == 0);
            send_frame(d, stop_bit, par_bit);
            check_eq("rnd_rx_valid", rx_valid, model_q.size() != 0);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                case ($urandom_range(0, 2))
                    0: chk_data("rnd_data");
                    1: chk_status("rnd_status");
                    default: begin
                        v = 8'($urandom);
                        clear_flags("rnd_clr", v);
                    end
                endcase
            end
        end
        chk_status("final_status");
        while (model_q.size() != 0) chk_data("drain_data");
        chk_data("empty_data");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
